// File: rtl/alu_bitop_seq_pkg.sv
// Shared ALU control-word definitions for the CB-prefix bit-operation sequencer.
package alu_bitop_seq_pkg;

    typedef enum logic [1:0] {
        CLS_ILL = 2'b00,
        CLS_BIT = 2'b01,
        CLS_RES = 2'b10,
        CLS_SET = 2'b11
    } bit_class_t;

    localparam logic [1:0] OE_NONE = 2'd0;
    localparam logic [1:0] BS_OE   = 2'd1;
    localparam logic [1:0] SH_OE   = 2'd2;
    localparam logic [1:0] RES_OE  = 2'd3;

    localparam logic BUS_LD = 1'b1;
    localparam logic NO_LD  = 1'b0;

    localparam logic [1:0] NO_SH = 2'b00;

    typedef struct packed {
        logic [2:0] bs;
        logic [7:0] op;
        logic [1:0] sh;
        logic [1:0] oe;
        logic       la;
        logic       lb;
        logic       r;
        logic       s;
        logic       v;
        logic       ne;
        logic       ci;
        logic       l;
        logic       h;
    } alu_line_t;

    localparam alu_line_t ALU_NOP = '{
        bs: 3'd0, op: 8'h00, sh: NO_SH, oe: OE_NONE, la: NO_LD, lb: NO_LD,
        r: 1'b0, s: 1'b0, v: 1'b0, ne: 1'b0, ci: 1'b0, l: 1'b0, h: 1'b0
    };

    typedef struct packed {
        logic r;
        logic s;
        logic v;
        logic ne;
    } class_flags_t;

    // r: write result back, s: OR the mask in, ne: AND with inverted mask, v: flags valid
    localparam class_flags_t SET_FLAGS = '{r: 1'b1, s: 1'b1, v: 1'b1, ne: 1'b0};
    localparam class_flags_t RES_FLAGS = '{r: 1'b1, s: 1'b0, v: 1'b1, ne: 1'b1};
    localparam class_flags_t BIT_FLAGS = '{r: 1'b0, s: 1'b0, v: 1'b1, ne: 1'b0};

    function automatic class_flags_t class_flags(input bit_class_t c);
        case (c)
            CLS_SET: return SET_FLAGS;
            CLS_RES: return RES_FLAGS;
            CLS_BIT: return BIT_FLAGS;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/alu_bitop_seq.sv
// Sequencer driving the ALU through mask build, operand load and result for BIT/RES/SET.
module alu_bitop_seq
    import alu_bitop_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic       ready,
    input  logic [7:0] opcode,
    input  logic [7:0] operand,
    output alu_line_t  line,
    input  logic [7:0] alu_result,
    input  logic       alu_zero,
    output logic [7:0] result,
    output logic       zero,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {IDLE, LBS, LOP, LRES, FIN} state_t;

    state_t       state;
    bit_class_t   cls;
    logic [7:0]   opnd;
    class_flags_t flags;
    logic         unused_bits;

    assign unused_bits = ^opcode[2:0];

    always_comb flags = class_flags(cls);

    // line is registered together with the state so it is valid for the whole state cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            ready  <= 1'b0;
            line   <= ALU_NOP;
            result <= '0;
            zero   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            cls    <= CLS_ILL;
            opnd   <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            line <= ALU_NOP;
            case (state)
                IDLE: begin
                    ready <= 1'b1;
                    if (start && ready) begin
                        if (opcode[7:6] == CLS_ILL) begin
                            err <= 1'b1;
                        end else begin
                            state   <= LBS;
                            ready   <= 1'b0;
                            cls     <= bit_class_t'(opcode[7:6]);
                            opnd    <= operand;
                            line.bs <= opcode[5:3];
                            line.oe <= BS_OE;
                            line.lb <= BUS_LD;
                            line.la <= NO_LD;
                        end
                    end
                end
                LBS: begin
                    state   <= LOP;
                    line.op <= opnd;
                    line.sh <= NO_SH;
                    line.oe <= SH_OE;
                    line.la <= BUS_LD;
                    line.lb <= NO_LD;
                    line.ci <= 1'b0;
                    line.l  <= 1'b1;
                    line.h  <= 1'b0;
                    line.r  <= flags.r;
                    line.s  <= flags.s;
                    line.v  <= flags.v;
                    line.ne <= flags.ne;
                end
                LOP: begin
                    state   <= LRES;
                    line.la <= NO_LD;
                    line.lb <= NO_LD;
                    line.ci <= 1'b0;
                    line.l  <= 1'b0;
                    line.h  <= 1'b1;
                    line.oe <= RES_OE;
                    line.r  <= flags.r;
                    line.s  <= flags.s;
                    line.v  <= flags.v;
                    line.ne <= flags.ne;
                end
                LRES: begin
                    state <= FIN;
                    done  <= 1'b1;
                    zero  <= alu_zero;
                    // BIT only tests; the previously captured byte is kept
                    if (cls != CLS_BIT) result <= alu_result;
                end
                FIN: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bitop_seq.sv
// Randomised scoreboard bench for alu_bitop_seq, paired with a behavioural ALU stand-in.
`timescale 1ns/1ps
module tb_alu_bitop_seq;
    import alu_bitop_seq_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       ready;
    logic [7:0] opcode = '0;
    logic [7:0] operand = '0;
    alu_line_t  line;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic [7:0] result;
    logic       zero;
    logic       done;
    logic       err;

    always #5 clk = ~clk;

    alu_bitop_seq dut (
        .clk(clk), .reset_n(reset_n), .start(start), .ready(ready),
        .opcode(opcode), .operand(operand), .line(line),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .result(result), .zero(zero), .done(done), .err(err)
    );

    // ALU stand-in: B latches the bit mask, A latches the operand, result combines them
    logic [7:0] a_reg = '0;
    logic [7:0] b_reg = '0;
    always @(posedge clk) begin
        if (line.lb == BUS_LD && line.oe == BS_OE) b_reg <= 8'h01 << line.bs;
        if (line.la == BUS_LD && line.oe == SH_OE) a_reg <= line.op;
    end
    always_comb begin
        alu_result = '0;
        if (line.oe == RES_OE)
            alu_result = line.s ? (a_reg | b_reg) : (line.ne ? (a_reg & ~b_reg) : (a_reg & b_reg));
        alu_zero = (alu_result == 8'h00);
    end

    typedef struct {
        bit          is_err;
        int unsigned edge_no;
        logic [7:0]  res;
        logic        zf;
    } exp_t;

    exp_t        sb[$];
    int unsigned cycle = 0;
    int          compared = 0;
    int          mismatched = 0;

    // reference-model state, owned by the stimulus process
    logic [7:0]  model_res = '0;
    logic        model_zero = 1'b0;
    int unsigned next_ok = 0;
    bit          acc_valid = 1'b0;
    int unsigned acc_edge = 0;
    logic [1:0]  acc_cls = '0;
    logic [2:0]  acc_bit = '0;
    logic [7:0]  acc_opnd = '0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    function automatic alu_line_t exp_line(input int phase, input logic [1:0] c,
                                           input logic [2:0] b, input logic [7:0] o);
        alu_line_t  x;
        logic [3:0] f;
        x = ALU_NOP;
        f = (c == 2'b11) ? 4'b1110 : ((c == 2'b10) ? 4'b1011 : 4'b0010);
        case (phase)
            0: begin
                x.bs = b; x.oe = BS_OE; x.lb = BUS_LD; x.la = NO_LD;
            end
            1: begin
                x.op = o; x.sh = NO_SH; x.oe = SH_OE; x.la = BUS_LD; x.lb = NO_LD;
                x.ci = 1'b0; x.l = 1'b1; x.h = 1'b0;
                {x.r, x.s, x.v, x.ne} = f;
            end
            2: begin
                x.la = NO_LD; x.lb = NO_LD; x.ci = 1'b0; x.l = 1'b0; x.h = 1'b1;
                x.oe = RES_OE;
                {x.r, x.s, x.v, x.ne} = f;
            end
            default: ;
        endcase
        return x;
    endfunction

    task automatic accept(input logic [7:0] opc, input logic [7:0] opd);
        int unsigned e;
        logic [7:0]  mask;
        exp_t        ent;
        e = cycle + 1;
        mask = 8'h01 << opc[5:3];
        if (opc[7:6] == 2'b00) begin
            ent = '{is_err: 1'b1, edge_no: e + 1, res: model_res, zf: model_zero};
            next_ok = e + 1;
        end else begin
            case (opc[7:6])
                2'b01: model_zero = ((opd & mask) == 8'h00);
                2'b10: begin model_res = opd & ~mask; model_zero = (model_res == 8'h00); end
                default: begin model_res = opd | mask; model_zero = (model_res == 8'h00); end
            endcase
            ent = '{is_err: 1'b0, edge_no: e + 4, res: model_res, zf: model_zero};
            next_ok = e + 5;
            acc_valid = 1'b1;
            acc_edge = e;
            acc_cls = opc[7:6];
            acc_bit = opc[5:3];
            acc_opnd = opd;
        end
        sb.push_back(ent);
    endtask

    // called at a falling edge; returns at the next falling edge
    task automatic drive(input logic st, input logic [7:0] opc, input logic [7:0] opd);
        start = st;
        opcode = opc;
        operand = opd;
        check("ready", {31'b0, ready}, {31'b0, (cycle + 1 >= next_ok)});
        if (st && ready) accept(opc, opd);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom), 8'($urandom));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_line"},   32'(line), 32'(ALU_NOP));
        check({tag, "_result"}, 32'(result), 32'h0);
        check({tag, "_zero"},   {31'b0, zero}, 32'h0);
        check({tag, "_done"},   {31'b0, done}, 32'h0);
        check({tag, "_err"},    {31'b0, err}, 32'h0);
        check({tag, "_ready"},  {31'b0, ready}, 32'h0);
    endtask

    // monitor: line every cycle, held outputs, and done/err against the scoreboard
    logic [7:0] held_res = '0;
    logic       held_zero = 1'b0;
    always @(negedge clk) begin
        int   phase;
        exp_t e;
        if (!reset_n) begin
            sb.delete();
            held_res = '0;
            held_zero = 1'b0;
        end else begin
            phase = acc_valid ? (int'(cycle) - int'(acc_edge)) : -1;
            check("line", 32'(line), 32'(exp_line(phase, acc_cls, acc_bit, acc_opnd)));
            check("carry", {31'b0, line.ci}, 32'h0);
            if (done || err) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_pulse: done=%0b err=%0b with nothing pending (cycle %0d)",
                             done, err, cycle);
                end else begin
                    e = sb.pop_front();
                    check("pulse_err",  {31'b0, err},  {31'b0, e.is_err});
                    check("pulse_done", {31'b0, done}, {31'b0, !e.is_err});
                    check("latency", cycle + 1, e.edge_no);
                    if (!e.is_err) begin
                        check("result", 32'(result), 32'(e.res));
                        check("zero", {31'b0, zero}, {31'b0, e.zf});
                        held_res = e.res;
                        held_zero = e.zf;
                    end
                end
            end else begin
                check("result_hold", 32'(result), 32'(held_res));
                check("zero_hold", {31'b0, zero}, {31'b0, held_zero});
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_reset_outputs("por");
        @(negedge clk);
        reset_n = 1'b1;
        next_ok = cycle + 2;
        idle(2);

        // directed: SET, RES, BIT (zero and non-zero), illegal class
        drive(1'b1, 8'hD8, 8'h00); idle(6);
        drive(1'b1, 8'hB8, 8'hFF); idle(6);
        drive(1'b1, 8'h48, 8'hFD); idle(6);
        drive(1'b1, 8'h48, 8'h02); idle(6);
        drive(1'b1, 8'h08, 8'h5A); idle(4);

        // reset while the sequencer is in LOP
        drive(1'b1, 8'hD8, 8'h00);
        drive(1'b0, 8'h00, 8'h00);
        reset_n = 1'b0;
        acc_valid = 1'b0;
        model_res = '0;
        model_zero = 1'b0;
        #1 check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        next_ok = cycle + 2;
        idle(8);
        drive(1'b1, 8'hE0, 8'h01); idle(6);

        // start held high: one SET every 5 cycles
        for (int i = 0; i < 16; i++) drive(1'b1, 8'hFF, 8'h00);
        idle(6);

        // random traffic, including illegal classes and requests while busy
        for (int i = 0; i < 300; i++)
            drive(1'($urandom_range(0, 2) != 0), 8'($urandom), 8'($urandom));
        idle(8);

        check("drain", sb.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_bitop_seq.md
ALU_BITOP_SEQ -- requirements
Module: alu_bitop_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state changes on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port start, input, 1 bit: request valid.
REQ-004 SHALL have port ready, output, 1 bit: sequencer can accept a request.
REQ-005 SHALL have port opcode, input, 8 bits: CB-prefixed opcode; [7:6] selects the class, [5:3] is the bit index, [2:0] is ignored.
REQ-006 SHALL have port operand, input, 8 bits: source byte, sampled on acceptance.
REQ-007 SHALL have port line, output, alu_line_t: ALU control word (bs, op, sh, oe, la, lb, r, s, v, ne, ci, l, h).
REQ-008 SHALL have port alu_result, input, 8 bits: ALU result bus.
REQ-009 SHALL have port alu_zero, input, 1 bit: ALU zero flag.
REQ-010 SHALL have port result, output, 8 bits: captured result.
REQ-011 SHALL have port zero, output, 1 bit: captured zero flag.
REQ-012 SHALL have port done, output, 1 bit: result/zero valid, single-cycle pulse.
REQ-013 SHALL have port err, output, 1 bit: illegal class, single-cycle pulse.

Function
REQ-014 SHALL decode opcode[7:6] as follows: 01 is BIT, 10 is RES, 11 is SET, 00 is illegal.
REQ-015 SHALL drive ready high only in state IDLE.
REQ-016 SHALL accept a request on a rising edge where start && ready, latching opcode and operand.
REQ-017 SHALL use states IDLE, LBS, LOP, LRES, FIN.
REQ-018 SHALL transition IDLE->LBS on a legal accept, LBS->LOP, LOP->LRES, LRES->FIN, FIN->IDLE, each unconditionally after one cycle.
REQ-019 SHALL, on an illegal accept, pulse err for the next cycle and stay in IDLE, with no ALU line other than NOP driven.
REQ-020 SHALL drive line in LBS as: bs=bit index, oe=BS_OE, lb=BUS_LD, la=NO_LD.
REQ-021 SHALL drive line in LOP as: op=latched operand, sh=NO_SH, oe=SH_OE, la=BUS_LD, lb=NO_LD, ci=0, l=1, h=0, and r/s/v/ne = the class flag constants.
REQ-022 SHALL drive line in LRES as: la=lb=NO_LD, ci=0, l=0, h=1, oe=RES_OE, and r/s/v/ne = the class flag constants.
REQ-023 SHALL drive line as ALU_NOP (no loads, no output enable) in IDLE and FIN.
REQ-024 SHALL capture alu_result into result and alu_zero into zero on the LRES->FIN edge.
REQ-025 SHALL hold done high for exactly the FIN cycle; result and zero SHALL hold until the next capture.
REQ-026 SHALL, for BIT, leave result unchanged and update only zero.
REQ-027 SHALL give a latency of 4 cycles from accept edge to done; back-to-back throughput is one request per 5 cycles.
REQ-028 SHALL ignore start outside IDLE, with no queueing.

Reset
REQ-029 SHALL, with reset_n low, immediately force state=IDLE, line=ALU_NOP, result=8'h00, zero=0, done=0, err=0; ready SHALL rise after reset_n deasserts.
REQ-030 SHALL, on reset mid-sequence, abandon the operation: no done and no capture.

Structure
REQ-031 SHALL place alu_line_t, the BS_OE/SH_OE/RES_OE, BUS_LD/NO_LD and NO_SH encodings, ALU_NOP, and the per-class r/s/v/ne constants (SET: r=s=v=1, ne=0) in the shared ALU package.
REQ-032 SHALL implement as a single module with no sub-module; the state machine plus datapath latches are flat.

Verification
REQ-033 SHALL cover, with the bench paired with the ALU: SET, opcode 0xD8 (bit 3), operand 0x00 -> done at accept+4, result=0x08, zero=0, carry never asserted.
REQ-034 SHALL cover: RES, opcode 0xB8 (bit 7), operand 0xFF -> result=0x7F, zero=0.
REQ-035 SHALL cover: BIT, opcode 0x48 (bit 1), operand 0xFD -> zero=1, result unchanged from its prior value; then operand 0x02 -> zero=0.
REQ-036 SHALL cover: opcode 0x08 -> err pulses one cycle, no done, line stays ALU_NOP, ready stays high.
REQ-037 SHALL cover: reset_n pulled low during LOP -> line=ALU_NOP and all outputs zero immediately, no done afterwards; a new SET then completes normally.
REQ-038 SHALL cover: start held high continuously with SET 0xFF, operand 0x00 -> one done every 5 cycles, result=0x80 each time, start ignored while busy.
